clock_key_conditioner: RTL and testbench
========================================

Name: clock_key_conditioner

Overview:
- Front-end user-input block for the clock/alarm design: the input-side counterpart of the display path.
- Takes the five raw push-buttons (Set_Clock, Set_Alarm, MIN, HR, Alarm_Off).
- Produces synchronized, debounced mode levels and single-cycle command pulses, with hold-to-auto-repeat on MIN/HR.
- Feeds the time, alarm and control blocks in place of raw pins.

Parameters:
- ACTIVE_LOW_KEYS, 1: 1 = raw key pressed when pin is 0; 0 = pressed when pin is 1.
- DEBOUNCE_CYCLES, 250000: consecutive clk cycles a synchronized key must differ from its stable state before the stable state flips (min 2).
- REPEAT_DELAY, 25000000: clk cycles from first MIN/HR pulse to first auto-repeat pulse while held.
- REPEAT_PERIOD, 5000000: clk cycles between subsequent auto-repeat pulses.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- key_set_clock  input  1  raw Set_Clock button
- key_set_alarm  input  1  raw Set_Alarm button
- key_min  input  1  raw MIN button
- key_hr  input  1  raw HR button
- key_alarm_off  input  1  raw Alarm_Off button
- set_clock_lvl  output  1  debounced level, 1 while Set_Clock held
- set_alarm_lvl  output  1  debounced level, 1 while Set_Alarm held
- min_pulse  output  1  one-cycle minute-increment command
- hr_pulse  output  1  one-cycle hour-increment command
- alarm_off_pulse  output  1  one-cycle alarm-off command

Behaviour:
- Reset (reset=0, async): all outputs 0; synchronizer flops, stable states and edge registers at "released"; debounce counters 0; repeat FSMs IDLE. Release is synchronous to clk.
- Polarity: each raw key is XORed with ACTIVE_LOW_KEYS, so internally 1 = pressed.
- Synchronizer: two flops per key. Debounce operates on the second flop output.
- Debounce, per key:
  - Counter clears whenever sync == stable.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES-1 the stable state flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Latency: a clean raw press at edge N gives stable=1 at edge N+DEBOUNCE_CYCLES+2. The level outputs equal stable directly.
- Alarm_off: alarm_off_pulse = 1 for exactly one cycle, the cycle after stable rises (rising edge of stable). No repeat; release generates nothing.
- set_mode = set_clock_lvl | set_alarm_lvl.
- MIN/HR repeat FSM (independent instance per key; one shared-width counter each, width = clog2(REPEAT_DELAY)):
  - IDLE: on stable rising edge with set_mode=1, emit pulse, load counter 0, go DELAY.
  - DELAY: counter increments. When counter == REPEAT_DELAY-1, emit pulse, clear counter, go REPEAT.
  - REPEAT: counter increments. When counter == REPEAT_PERIOD-1, emit pulse, clear counter, stay.
  - Any state: stable=0 or set_mode=0 sends the FSM to IDLE next cycle with no pulse; this takes priority over a pulse in the same cycle.
  - Press while set_mode=0: no pulse. Asserting set_mode later while the key is held still gives no pulse, because a fresh rising edge is required.
- Simultaneous events: MIN and HR FSMs run independently; both may pulse in the same cycle. Set_Clock and Set_Alarm levels are independent; arbitrating between them is the downstream control block's job.
- Reset mid-hold: everything returns to reset values. After release, a key still physically held debounces to pressed; its edge produces a pulse if set_mode=1.
- Pulses never exceed one cycle. Minimum spacing between MIN pulses is min(REPEAT_DELAY, REPEAT_PERIOD) cycles.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, ACTIVE_LOW_KEYS=1):
- Reset check: reset=0 with all keys=1 -> all outputs 0. Release reset, hold 50 cycles -> outputs stay 0.
- Debounce glitch: key_alarm_off low 3 cycles, then high -> no alarm_off_pulse. Low 10 cycles -> exactly one alarm_off_pulse, 7 edges after the falling input (4+2, then pulse cycle).
- Set level: key_set_clock low 40 cycles -> set_clock_lvl=1 from edge 6 after press until edge 6 after release.
- Auto-repeat: hold key_set_clock low, then hold key_min low 60 cycles -> min_pulse at first-pulse cycle T, then T+20, T+28, T+36, …; none after release debounces.
- Mode gate: key_min pressed with no set key held -> zero min_pulse. Press key_set_alarm mid-hold -> still zero. Release and re-press key_min -> pulse.
- Concurrent and reset: MIN and HR pressed the same cycle in set mode -> coincident min_pulse/hr_pulse. reset=0 mid-REPEAT -> pulses stop immediately; after release with keys held -> one fresh pulse each, after debounce.

Source files
------------

// File: rtl/clock_key_conditioner.sv
// Push-button front end for the clock/alarm: synchronizes and debounces five keys,
// emits single-cycle commands, and auto-repeats MIN/HR while held in a set mode.
`timescale 1ns/1ps

module ckc_debounce #(
  parameter int ACTIVE_LOW_KEYS = 1,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_stable
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          w_key;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_stable;

  assign w_key    = i_key ^ (ACTIVE_LOW_KEYS != 0);
  assign o_stable = r_stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], w_key};
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module ckc_repeat #(
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stable,
  input  logic i_rise,
  input  logic i_set_mode,
  output logic o_pulse
);
  localparam int CW = (REPEAT_DELAY > 2) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_emit;
  logic          r_pulse;

  assign o_pulse = r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_emit;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_emit      = 1'b0;
    // Key release or leaving set mode wins over any pulse due this cycle.
    if (!i_stable || !i_set_mode) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (i_rise) begin
            w_emit      = 1'b1;
            w_state_nxt = S_DELAY;
          end
        end
        S_DELAY: begin
          if (r_cnt == DLY_LAST) begin
            w_emit      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_REPEAT;
          end
        end
        S_REPEAT: begin
          if (r_cnt == PER_LAST) begin
            w_emit    = 1'b1;
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end
endmodule

module clock_key_conditioner #(
  parameter int ACTIVE_LOW_KEYS = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_set_clock,
  input  logic key_set_alarm,
  input  logic key_min,
  input  logic key_hr,
  input  logic key_alarm_off,
  output logic set_clock_lvl,
  output logic set_alarm_lvl,
  output logic min_pulse,
  output logic hr_pulse,
  output logic alarm_off_pulse
);
  localparam int NUM_KEYS = 5;

  // Key index: 0 set_clock, 1 set_alarm, 2 min, 3 hr, 4 alarm_off.
  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] w_stable;
  logic [NUM_KEYS-1:2] r_prev;
  logic [NUM_KEYS-1:2] w_rise;
  logic [1:0]          w_rep;
  logic                w_set_mode;
  logic                r_aoff;

  assign w_raw = {key_alarm_off, key_hr, key_min, key_set_alarm, key_set_clock};

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_deb
      ckc_debounce #(
        .ACTIVE_LOW_KEYS(ACTIVE_LOW_KEYS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk     (clk),
        .rst_n   (reset),
        .i_key   (w_raw[g]),
        .o_stable(w_stable[g])
      );
    end
  endgenerate

  assign w_rise     = w_stable[NUM_KEYS-1:2] & ~r_prev;
  assign w_set_mode = w_stable[0] | w_stable[1];

  generate
    for (g = 0; g < 2; g++) begin : g_rep
      ckc_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_rep (
        .clk       (clk),
        .rst_n     (reset),
        .i_stable  (w_stable[g+2]),
        .i_rise    (w_rise[g+2]),
        .i_set_mode(w_set_mode),
        .o_pulse   (w_rep[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= '0;
      r_aoff <= 1'b0;
    end else begin
      r_prev <= w_stable[NUM_KEYS-1:2];
      r_aoff <= w_rise[4];
    end
  end

  assign set_clock_lvl   = w_stable[0];
  assign set_alarm_lvl   = w_stable[1];
  assign min_pulse       = w_rep[0];
  assign hr_pulse        = w_rep[1];
  assign alarm_off_pulse = r_aoff;
endmodule

// File: tb/tb_clock_key_conditioner.sv
// Directed bench for clock_key_conditioner with short debounce/repeat timing;
// pulse times are logged per cycle and compared with hand-derived edge numbers.
`timescale 1ns/1ps

module tb_clock_key_conditioner;
  logic clk, reset;
  logic key_set_clock, key_set_alarm, key_min, key_hr, key_alarm_off;
  logic set_clock_lvl, set_alarm_lvl, min_pulse, hr_pulse, alarm_off_pulse;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hi_cnt = 0;
  int sc_rise = -1, sc_fall = -1;
  logic sc_prev = 1'b0;
  int min_q[$], hr_q[$], aoff_q[$];

  clock_key_conditioner #(
    .ACTIVE_LOW_KEYS(1),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_set_clock  (key_set_clock),
    .key_set_alarm  (key_set_alarm),
    .key_min        (key_min),
    .key_hr         (key_hr),
    .key_alarm_off  (key_alarm_off),
    .set_clock_lvl  (set_clock_lvl),
    .set_alarm_lvl  (set_alarm_lvl),
    .min_pulse      (min_pulse),
    .hr_pulse       (hr_pulse),
    .alarm_off_pulse(alarm_off_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (min_pulse) min_q.push_back(cyc);
    if (hr_pulse) hr_q.push_back(cyc);
    if (alarm_off_pulse) aoff_q.push_back(cyc);
    if (set_clock_lvl | set_alarm_lvl | min_pulse | hr_pulse | alarm_off_pulse) hi_cnt++;
    if (set_clock_lvl && !sc_prev) sc_rise = cyc;
    if (!set_clock_lvl && sc_prev) sc_fall = cyc;
    sc_prev = set_clock_lvl;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int outs();
    return int'({set_clock_lvl, set_alarm_lvl, min_pulse, hr_pulse, alarm_off_pulse});
  endfunction

  initial begin
    int n, m;
    int rep_off[6] = '{7, 27, 35, 43, 51, 59};

    reset = 1'b0;
    {key_set_clock, key_set_alarm, key_min, key_hr, key_alarm_off} = 5'b11111;
    tick(3);
    chk("reset_outs", outs(), 0);
    hi_cnt = 0;
    reset = 1'b1;
    tick(50);
    chk("idle_no_activity", hi_cnt, 0);

    // 3-cycle glitch is filtered, 10-cycle press gives one pulse at +7
    aoff_q.delete();
    key_alarm_off = 1'b0;
    tick(3);
    key_alarm_off = 1'b1;
    tick(20);
    chk("glitch_no_pulse", aoff_q.size(), 0);
    n = cyc;
    key_alarm_off = 1'b0;
    tick(10);
    key_alarm_off = 1'b1;
    tick(20);
    chk("aoff_count", aoff_q.size(), 1);
    chk("aoff_time", qat(aoff_q, 0), n + 7);

    // set_clock level tracks the debounced key both ways
    n = cyc;
    key_set_clock = 1'b0;
    tick(40);
    key_set_clock = 1'b1;
    tick(20);
    chk("setclk_rise", sc_rise, n + 6);
    chk("setclk_fall", sc_fall, n + 46);

    // auto-repeat: T, T+20, then every 8 until release debounces
    key_set_clock = 1'b0;
    tick(10);
    min_q.delete();
    n = cyc;
    key_min = 1'b0;
    tick(60);
    key_min = 1'b1;
    tick(30);
    chk("rep_count", min_q.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rep_time%0d", i), qat(min_q, i), n + rep_off[i]);
    key_set_clock = 1'b1;
    tick(20);

    // mode gate: a fresh press edge inside set mode is required
    min_q.delete();
    key_min = 1'b0;
    tick(30);
    chk("gate_nomode", min_q.size(), 0);
    key_set_alarm = 1'b0;
    tick(30);
    chk("gate_late_mode", min_q.size(), 0);
    chk("setalm_lvl", int'(set_alarm_lvl), 1);
    key_min = 1'b1;
    tick(15);
    n = cyc;
    key_min = 1'b0;
    tick(15);
    chk("gate_repress_cnt", min_q.size(), 1);
    chk("gate_repress_time", qat(min_q, 0), n + 7);
    key_min = 1'b1;
    key_set_alarm = 1'b1;
    tick(20);

    // concurrent MIN/HR, then reset mid-REPEAT with keys still held
    key_set_clock = 1'b0;
    tick(10);
    min_q.delete();
    hr_q.delete();
    n = cyc;
    key_min = 1'b0;
    key_hr = 1'b0;
    tick(40);
    chk("conc_min_cnt", min_q.size(), 3);
    chk("conc_hr_cnt", hr_q.size(), 3);
    chk("conc_min_t0", qat(min_q, 0), n + 7);
    chk("conc_hr_t0", qat(hr_q, 0), n + 7);
    chk("conc_hr_t2", qat(hr_q, 2), n + 35);
    reset = 1'b0;
    #1;
    chk("midreset_outs", outs(), 0);
    min_q.delete();
    hr_q.delete();
    tick(5);
    chk("inreset_min", min_q.size(), 0);
    chk("inreset_hr", hr_q.size(), 0);
    m = cyc;
    reset = 1'b1;
    tick(15);
    chk("post_min_cnt", min_q.size(), 1);
    chk("post_hr_cnt", hr_q.size(), 1);
    chk("post_min_time", qat(min_q, 0), m + 7);
    chk("post_hr_time", qat(hr_q, 0), m + 7);
    chk("post_setclk", int'(set_clock_lvl), 1);
    {key_set_clock, key_set_alarm, key_min, key_hr, key_alarm_off} = 5'b11111;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
